// File: rtl/ahb_burst_sequencer.sv
// AHB master burst sequencer: arbitrates for the bus, drives the pipelined address phase and
// recovers from grant loss and ERROR/RETRY/SPLIT responses while reporting per-beat completions.
module ahb_burst_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [4:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_write,
  output logic              hbusreq,
  input  logic              hgrant,
  input  logic              hready,
  input  logic [1:0]        hresp,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic              beat_valid,
  output logic [3:0]        beat_idx,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_LAST} state_t;

  localparam logic [1:0] TR_IDLE    = 2'd0;
  localparam logic [1:0] TR_NONSEQ  = 2'd2;
  localparam logic [1:0] TR_SEQ     = 2'd3;
  localparam logic [1:0] RESP_OKAY  = 2'd0;
  localparam logic [1:0] RESP_ERROR = 2'd1;
  localparam logic [2:0] B_SINGLE   = 3'd0;
  localparam logic [2:0] B_INCR     = 3'd1;
  localparam int         MAX_SIZE   = $clog2(DATA_W / 8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;          // next unissued address
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;  // address of the beat in data phase
  logic              dp_vld_q, dp_vld_d;
  logic [3:0]        dp_idx_q, dp_idx_d;
  logic [4:0]        issued_q, issued_d;
  logic [4:0]        total_q, total_d;
  logic [2:0]        bmode_q, bmode_d;
  logic              reissue_q, reissue_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_d;
  logic [2:0]        hburst_d, hsize_d;
  logic              hwrite_d, hbusreq_d, beat_valid_d, done_d, err_d;
  logic [3:0]        beat_idx_d;

  logic [2:0]        size_eff;
  logic [4:0]        cmd_beats;
  logic [12:0]       span;
  logic              cmd_crosses;
  logic [ADDR_W-1:0] step, inc, wrap_mask, nxt;
  logic              contig, fixed_seq, resp_fail;
  logic [4:0]        remain;

  always_comb begin
    size_eff = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
    case (cmd_burst)
      3'd0:       cmd_beats = 5'd1;
      3'd1:       cmd_beats = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
      3'd2, 3'd3: cmd_beats = 5'd4;
      3'd4, 3'd5: cmd_beats = 5'd8;
      default:    cmd_beats = 5'd16;
    endcase
    // fixed-length INCRn may not run past the next 1KB line
    span        = {3'b000, cmd_addr[9:0]} + (13'(cmd_beats) << size_eff);
    cmd_crosses = cmd_burst[0] && (cmd_burst[2:1] != 2'b00) && (span > 13'h400);
  end

  always_comb begin
    step      = ADDR_W'(1) << hsize;
    inc       = haddr + step;
    wrap_mask = (bmode_q[0] == 1'b0 && bmode_q != B_SINGLE) ?
                ((ADDR_W'(total_q) << hsize) - ADDR_W'(1)) : '1;
    nxt       = (haddr & ~wrap_mask) | (inc & wrap_mask);
    contig    = (nxt == inc) && (nxt[9:0] != 10'd0);
    fixed_seq = !reissue_q && (bmode_q != B_INCR);
    remain    = total_q - issued_q;
    resp_fail = dp_vld_q && !hready && (hresp != RESP_OKAY);
  end

  // the first cycle of a two-cycle response must not expose the next address
  assign htrans    = resp_fail ? TR_IDLE : htrans_q;
  assign cmd_ready = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dp_addr_d    = dp_addr_q;
    dp_vld_d     = dp_vld_q;
    dp_idx_d     = dp_idx_q;
    issued_d     = issued_q;
    total_d      = total_q;
    bmode_d      = bmode_q;
    reissue_d    = reissue_q;
    htrans_d     = htrans_q;
    haddr_d      = haddr;
    hburst_d     = hburst;
    hsize_d      = hsize;
    hwrite_d     = hwrite;
    hbusreq_d    = hbusreq;
    beat_valid_d = 1'b0;
    beat_idx_d   = beat_idx;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (dp_vld_q && hready) begin
      dp_vld_d = 1'b0;
      if (hresp == RESP_OKAY) begin
        beat_valid_d = 1'b1;
        beat_idx_d   = dp_idx_q;
        if ({1'b0, dp_idx_q} == total_q - 5'd1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    end

    case (state_q)
      S_IDLE: if (cmd_valid) begin
        if (cmd_crosses) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          state_d   = S_REQ;
          hbusreq_d = 1'b1;
          ptr_d     = cmd_addr;
          issued_d  = 5'd0;
          total_d   = cmd_beats;
          bmode_d   = cmd_burst;
          reissue_d = 1'b0;
          hsize_d   = size_eff;
          hwrite_d  = cmd_write;
        end
      end
      S_REQ: if (hgrant && hready) begin
        state_d  = S_ADDR;
        haddr_d  = ptr_q;
        htrans_d = TR_NONSEQ;
        hburst_d = !reissue_q ? bmode_q : ((remain == 5'd1) ? B_SINGLE : B_INCR);
      end
      S_ADDR: if (hready) begin
        dp_vld_d  = 1'b1;
        dp_idx_d  = issued_q[3:0];
        dp_addr_d = haddr;
        issued_d  = issued_q + 5'd1;
        if (issued_q + 5'd1 == total_q) begin
          state_d   = S_LAST;
          htrans_d  = TR_IDLE;
          hbusreq_d = 1'b0;
        end else if (!hgrant) begin
          state_d   = S_REQ;
          htrans_d  = TR_IDLE;
          ptr_d     = nxt;
          reissue_d = 1'b1;
        end else begin
          haddr_d  = nxt;
          htrans_d = (fixed_seq || contig) ? TR_SEQ : TR_NONSEQ;
        end
      end
      default: ;
    endcase

    if (resp_fail) begin
      htrans_d = TR_IDLE;
      if (hresp == RESP_ERROR) begin
        state_d   = S_IDLE;
        hbusreq_d = 1'b0;
        done_d    = 1'b1;
        err_d     = 1'b1;
      end else begin
        // RETRY/SPLIT: rewind to the failed beat and re-arbitrate
        state_d   = S_REQ;
        hbusreq_d = 1'b1;
        ptr_d     = dp_addr_q;
        issued_d  = {1'b0, dp_idx_q};
        reissue_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      dp_addr_q  <= '0;
      dp_vld_q   <= 1'b0;
      dp_idx_q   <= 4'd0;
      issued_q   <= 5'd0;
      total_q    <= 5'd0;
      bmode_q    <= 3'd0;
      reissue_q  <= 1'b0;
      htrans_q   <= TR_IDLE;
      haddr      <= '0;
      hburst     <= 3'd0;
      hsize      <= 3'd0;
      hwrite     <= 1'b0;
      hbusreq    <= 1'b0;
      beat_valid <= 1'b0;
      beat_idx   <= 4'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dp_addr_q  <= dp_addr_d;
      dp_vld_q   <= dp_vld_d;
      dp_idx_q   <= dp_idx_d;
      issued_q   <= issued_d;
      total_q    <= total_d;
      bmode_q    <= bmode_d;
      reissue_q  <= reissue_d;
      htrans_q   <= htrans_d;
      haddr      <= haddr_d;
      hburst     <= hburst_d;
      hsize      <= hsize_d;
      hwrite     <= hwrite_d;
      hbusreq    <= hbusreq_d;
      beat_valid <= beat_valid_d;
      beat_idx   <= beat_idx_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Directed bench for ahb_burst_sequencer: expected address phases, beat indices and done/err
// outcomes are queued as each command is issued and consumed as the bus shows them.
module tb_ahb_burst_sequencer;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [4:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic        hbusreq;
  logic        hgrant;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        beat_valid;
  logic [3:0]  beat_idx;
  logic        done;
  logic        err;

  ahb_burst_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_write(cmd_write),
    .hbusreq(hbusreq), .hgrant(hgrant), .hready(hready), .hresp(hresp),
    .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
    .beat_valid(beat_valid), .beat_idx(beat_idx), .done(done), .err(err)
  );

  always #5 hclk = ~hclk;

  localparam logic [1:0] N = 2'd2, S = 2'd3;
  localparam logic [1:0] OKAY = 2'd0, ERROR = 2'd1, SPLIT = 2'd3;

  logic [40:0] aq[$];   // {haddr, htrans, hburst, hsize, hwrite}
  int          bq[$];
  logic        dq[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_a(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                                 input logic [2:0] s, input logic w);
    aq.push_back({a, t, b, s, w});
  endfunction

  function automatic void push_beats(input int first, input int last);
    for (int i = first; i <= last; i++) bq.push_back(i);
  endfunction

  always @(negedge hclk) begin
    if (mon_en) begin
      if (htrans != 2'd0 && hready) begin
        if (aq.size() == 0) check("addr_unexpected", {62'd0, htrans}, 64'd0);
        else check("addr_phase", {23'd0, haddr, htrans, hburst, hsize, hwrite}, {23'd0, aq.pop_front()});
      end
      if (beat_valid) begin
        if (bq.size() == 0) check("beat_unexpected", {63'd0, beat_valid}, 64'd0);
        else check("beat_idx", {60'd0, beat_idx}, 64'(bq.pop_front()));
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", {63'd0, done}, 64'd0);
        else check("done_err", {63'd0, err}, {63'd0, dq.pop_front()});
      end
    end
  end

  task automatic cyc(input logic g, input logic r, input logic [1:0] rs);
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    hgrant    = g;
    hready    = r;
    hresp     = rs;
    @(negedge hclk);
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] b, input logic [4:0] l,
                      input logic [2:0] s, input logic w);
    @(posedge hclk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_burst = b;
    cmd_len   = l;
    cmd_size  = s;
    cmd_write = w;
    hgrant    = 1'b0;
    hready    = 1'b1;
    hresp     = OKAY;
    @(negedge hclk);
    check("cmd_ready", {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic run_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1'b1, 1'b1, OKAY);
      seen = done;
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_busreq_low"}, {63'd0, hbusreq}, 64'd0);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_len = '0; cmd_size = '0; cmd_write = 1'b0;
    hgrant = 1'b0; hready = 1'b1; hresp = OKAY;
    repeat (2) @(negedge hclk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_hbusreq", {63'd0, hbusreq}, 64'd0);
    check("rst_htrans", {62'd0, htrans}, 64'd0);
    check("rst_haddr", {32'd0, haddr}, 64'd0);
    check("rst_hburst", {61'd0, hburst}, 64'd0);
    check("rst_hsize", {61'd0, hsize}, 64'd0);
    check("rst_hwrite", {63'd0, hwrite}, 64'd0);
    check("rst_beat_valid", {63'd0, beat_valid}, 64'd0);
    check("rst_beat_idx", {60'd0, beat_idx}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge hclk); #1 hreset_n = 1'b1;
    mon_en = 1'b1;

    // INCR4 @0x100, size 2, write
    push_a(32'h100, N, 3'd3, 3'd2, 1'b1); push_a(32'h104, S, 3'd3, 3'd2, 1'b1);
    push_a(32'h108, S, 3'd3, 3'd2, 1'b1); push_a(32'h10C, S, 3'd3, 3'd2, 1'b1);
    push_beats(0, 3); dq.push_back(1'b0);
    send(32'h100, 3'd3, 5'd0, 3'd2, 1'b1);
    run_done("incr4", 30);

    // WRAP4 @0x38 with a wait state while beat 1 is on the address bus
    push_a(32'h38, N, 3'd2, 3'd2, 1'b0); push_a(32'h3C, S, 3'd2, 3'd2, 1'b0);
    push_a(32'h30, S, 3'd2, 3'd2, 1'b0); push_a(32'h34, S, 3'd2, 3'd2, 1'b0);
    push_beats(0, 3); dq.push_back(1'b0);
    send(32'h38, 3'd2, 5'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b0, OKAY);
    check("wrap_wait_haddr", {32'd0, haddr}, 64'h3C);
    check("wrap_wait_htrans", {62'd0, htrans}, {62'd0, S});
    cyc(1'b1, 1'b1, OKAY);
    check("wrap_held_haddr", {32'd0, haddr}, 64'h3C);
    run_done("wrap4", 30);

    // undefined INCR across the 1KB line restarts with NONSEQ
    push_a(32'h3F8, N, 3'd1, 3'd2, 1'b0); push_a(32'h3FC, S, 3'd1, 3'd2, 1'b0);
    push_a(32'h400, N, 3'd1, 3'd2, 1'b0); push_a(32'h404, S, 3'd1, 3'd2, 1'b0);
    push_beats(0, 3); dq.push_back(1'b0);
    send(32'h3F8, 3'd1, 5'd4, 3'd2, 1'b0);
    run_done("incr_1kb", 30);

    // fixed INCR4 across 1KB: rejected with no bus activity
    dq.push_back(1'b1);
    send(32'h3F8, 3'd3, 5'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, OKAY);
    check("x1kb_done", {63'd0, done}, 64'd1);
    check("x1kb_err", {63'd0, err}, 64'd1);
    check("x1kb_busreq", {63'd0, hbusreq}, 64'd0);
    repeat (3) cyc(1'b1, 1'b1, OKAY);
    check("x1kb_htrans", {62'd0, htrans}, 64'd0);

    // INCR8 @0x0, grant lost after two addresses
    push_a(32'h0, N, 3'd5, 3'd2, 1'b0); push_a(32'h4, S, 3'd5, 3'd2, 1'b0);
    push_a(32'h8, N, 3'd1, 3'd2, 1'b0);
    for (int i = 3; i < 8; i++) push_a(32'(i * 4), S, 3'd1, 3'd2, 1'b0);
    push_beats(0, 7); dq.push_back(1'b0);
    send(32'h0, 3'd5, 5'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b0, 1'b1, OKAY);
    cyc(1'b0, 1'b1, OKAY);
    check("gloss_htrans", {62'd0, htrans}, 64'd0);
    check("gloss_busreq", {63'd0, hbusreq}, 64'd1);
    cyc(1'b0, 1'b1, OKAY);
    check("gloss_busreq_held", {63'd0, hbusreq}, 64'd1);
    run_done("gloss", 40);

    // ERROR on beat 1 of INCR4 @0x0
    push_a(32'h0, N, 3'd3, 3'd2, 1'b0); push_a(32'h4, S, 3'd3, 3'd2, 1'b0);
    push_beats(0, 0); dq.push_back(1'b1);
    send(32'h0, 3'd3, 5'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b0, ERROR);
    check("error_first_htrans", {62'd0, htrans}, 64'd0);
    cyc(1'b1, 1'b1, ERROR);
    check("error_done", {63'd0, done}, 64'd1);
    check("error_err", {63'd0, err}, 64'd1);
    check("error_busreq", {63'd0, hbusreq}, 64'd0);
    check("error_htrans", {62'd0, htrans}, 64'd0);
    repeat (3) cyc(1'b0, 1'b1, OKAY);
    check("error_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // SPLIT on beat 2 of INCR4, then re-grant
    push_a(32'h0, N, 3'd3, 3'd2, 1'b0); push_a(32'h4, S, 3'd3, 3'd2, 1'b0);
    push_a(32'h8, S, 3'd3, 3'd2, 1'b0);
    push_a(32'h8, N, 3'd1, 3'd2, 1'b0); push_a(32'hC, S, 3'd1, 3'd2, 1'b0);
    push_beats(0, 3); dq.push_back(1'b0);
    send(32'h0, 3'd3, 5'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b0, SPLIT);
    check("split_first_htrans", {62'd0, htrans}, 64'd0);
    cyc(1'b0, 1'b1, SPLIT);
    check("split_htrans", {62'd0, htrans}, 64'd0);
    check("split_busreq", {63'd0, hbusreq}, 64'd1);
    cyc(1'b0, 1'b1, OKAY);
    run_done("split", 30);

    // reset in the middle of an INCR16
    push_a(32'h200, N, 3'd7, 3'd2, 1'b1); push_a(32'h204, S, 3'd7, 3'd2, 1'b1);
    push_beats(0, 0);
    send(32'h200, 3'd7, 5'd0, 3'd2, 1'b1);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b1, OKAY);
    cyc(1'b1, 1'b0, OKAY);
    #2 hreset_n = 1'b0;
    #1;
    check("mrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("mrst_hbusreq", {63'd0, hbusreq}, 64'd0);
    check("mrst_htrans", {62'd0, htrans}, 64'd0);
    check("mrst_haddr", {32'd0, haddr}, 64'd0);
    check("mrst_hburst", {61'd0, hburst}, 64'd0);
    check("mrst_hwrite", {63'd0, hwrite}, 64'd0);
    check("mrst_beat_valid", {63'd0, beat_valid}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    @(posedge hclk); #1 hreset_n = 1'b1;
    repeat (4) cyc(1'b1, 1'b1, OKAY);
    check("post_rst_busreq", {63'd0, hbusreq}, 64'd0);
    check("post_rst_htrans", {62'd0, htrans}, 64'd0);

    check("aq_left", 64'(aq.size()), 64'd0);
    check("bq_left", 64'(bq.size()), 64'd0);
    check("dq_left", 64'(dq.size()), 64'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
